// File: rtl/bin2bcd_seg_driver.sv
// Converts an 8-bit result (unsigned or two's complement) to sign + 3 BCD digits
// with a double-dabble FSM, and scans them onto a 4-digit active-low 7-segment display.
module bin2bcd_seg_driver #(
  parameter int CLK_DIV = 50000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic [7:0] value,
  input  logic       signed_mode,
  output logic       busy,
  output logic       done,
  output logic [6:0] seg,
  output logic [3:0] an
);

  typedef enum logic [1:0] {IDLE, LOAD, SHIFT, DONE} state_t;

  localparam int PW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [6:0] SEG_BLANK = 7'b1111111;
  localparam logic [6:0] SEG_MINUS = 7'b0111111;

  state_t          state_q, state_d;
  logic [7:0]      val_q, val_d;
  logic            sm_q, sm_d;
  logic [7:0]      mag_q, mag_d;
  logic [11:0]     bcd_q, bcd_d;
  logic [2:0]      cnt_q, cnt_d;
  logic            negw_q, negw_d;
  logic            neg_q, neg_d;
  logic [3:0]      hun_q, hun_d, ten_q, ten_d, uni_q, uni_d;
  logic [PW-1:0]   presc_q, presc_d;
  logic [1:0]      idx_q, idx_d;
  logic            busy_q, busy_d, done_q, done_d;
  logic [6:0]      seg_q, seg_d;
  logic [3:0]      an_q, an_d;
  logic [11:0]     bcd_adj, bcd_shift;

  function automatic logic [3:0] add3(input logic [3:0] n);
    return (n >= 4'd5) ? n + 4'd3 : n;
  endfunction

  function automatic logic [6:0] digit_code(input logic [3:0] d);
    case (d)
      4'd0:    return 7'b1000000;
      4'd1:    return 7'b1111001;
      4'd2:    return 7'b0100100;
      4'd3:    return 7'b0110000;
      4'd4:    return 7'b0011001;
      4'd5:    return 7'b0010010;
      4'd6:    return 7'b0000010;
      4'd7:    return 7'b1111000;
      4'd8:    return 7'b0000000;
      4'd9:    return 7'b0010000;
      default: return SEG_BLANK;
    endcase
  endfunction

  always_comb begin
    // NOTE: every _d starts as its _q so no path through this block leaves a variable unassigned (no latches).
    state_d  = state_q;
    val_d    = val_q;
    sm_d     = sm_q;
    mag_d    = mag_q;
    bcd_d    = bcd_q;
    cnt_d    = cnt_q;
    negw_d   = negw_q;
    neg_d    = neg_q;
    hun_d    = hun_q;
    ten_d    = ten_q;
    uni_d    = uni_q;
    bcd_adj   = {add3(bcd_q[11:8]), add3(bcd_q[7:4]), add3(bcd_q[3:0])};
    bcd_shift = 12'({bcd_adj, mag_q[7]});

    case (state_q)
      IDLE, DONE: begin
        state_d = IDLE;
        if (start) begin
          val_d   = value;
          sm_d    = signed_mode;
          state_d = LOAD;
        end
      end
      LOAD: begin
        negw_d  = sm_q & val_q[7];
        mag_d   = (sm_q & val_q[7]) ? 8'(9'd0 - {1'b0, val_q}) : val_q;
        bcd_d   = '0;
        cnt_d   = '0;
        state_d = SHIFT;
      end
      SHIFT: begin
        bcd_d = bcd_shift;
        mag_d = mag_q << 1;
        cnt_d = cnt_q + 3'd1;
        if (cnt_q == 3'd7) begin
          // Display only changes on the edge that enters DONE.
          state_d = DONE;
          neg_d   = negw_q;
          hun_d   = bcd_shift[11:8];
          ten_d   = bcd_shift[7:4];
          uni_d   = bcd_shift[3:0];
        end
      end
      default: state_d = IDLE;
    endcase

    busy_d = (state_d == LOAD) || (state_d == SHIFT);
    done_d = (state_d == DONE);

    presc_d = presc_q + PW'(1);
    idx_d   = idx_q;
    if (presc_q == PW'(CLK_DIV - 1)) begin
      presc_d = '0;
      idx_d   = idx_q + 2'd1;
    end

    // Outputs are computed from next-state values so seg/an stay aligned with idx and display.
    an_d = ~(4'b0001 << idx_d);
    case (idx_d)
      2'd3:    seg_d = neg_d ? SEG_MINUS : SEG_BLANK;
      2'd2:    seg_d = (hun_d == 4'd0) ? SEG_BLANK : digit_code(hun_d);
      2'd1:    seg_d = (hun_d == 4'd0 && ten_d == 4'd0) ? SEG_BLANK : digit_code(ten_d);
      default: seg_d = digit_code(uni_d);
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update together at the edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      val_q   <= '0;
      sm_q    <= 1'b0;
      mag_q   <= '0;
      bcd_q   <= '0;
      cnt_q   <= '0;
      negw_q  <= 1'b0;
      neg_q   <= 1'b0;
      hun_q   <= '0;
      ten_q   <= '0;
      uni_q   <= '0;
      presc_q <= '0;
      idx_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      seg_q   <= 7'b1000000;
      an_q    <= 4'b1110;
    end else begin
      state_q <= state_d;
      val_q   <= val_d;
      sm_q    <= sm_d;
      mag_q   <= mag_d;
      bcd_q   <= bcd_d;
      cnt_q   <= cnt_d;
      negw_q  <= negw_d;
      neg_q   <= neg_d;
      hun_q   <= hun_d;
      ten_q   <= ten_d;
      uni_q   <= uni_d;
      presc_q <= presc_d;
      idx_q   <= idx_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      seg_q   <= seg_d;
      an_q    <= an_d;
    end
  end

  assign busy = busy_q;
  assign done = done_q;
  assign seg  = seg_q;
  assign an   = an_q;

endmodule

// File: tb/tb_bin2bcd_seg_driver.sv
// Self-checking bench for bin2bcd_seg_driver: latency, display contents, scan order,
// ignored starts, abort by reset, back-to-back starts and randomized values.
module tb_bin2bcd_seg_driver;

  localparam int CLK_DIV = 4;

  logic       clk = 1'b0;
  logic       rst, start, signed_mode;
  logic [7:0] value;
  logic       busy, done;
  logic [6:0] seg;
  logic [3:0] an;

  int errors = 0;
  int checks = 0;

  // Value currently expected on the display.
  logic [7:0] cur_v;
  logic       cur_sm;

  bin2bcd_seg_driver #(.CLK_DIV(CLK_DIV)) dut (
    .clk(clk), .rst(rst), .start(start), .value(value), .signed_mode(signed_mode),
    .busy(busy), .done(done), .seg(seg), .an(an)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end

  function automatic logic [6:0] code_of(input int d);
    case (d)
      0: return 7'b1000000;  1: return 7'b1111001;  2: return 7'b0100100;
      3: return 7'b0110000;  4: return 7'b0011001;  5: return 7'b0010010;
      6: return 7'b0000010;  7: return 7'b1111000;  8: return 7'b0000000;
      9: return 7'b0010000;  default: return 7'b1111111;
    endcase
  endfunction

  // Reference: decimal digits derived by plain arithmetic on the interpreted value.
  function automatic logic [6:0] exp_seg(input int pos, input logic [7:0] v, input logic sm);
    int mag, h, t, u;
    bit neg;
    neg = sm && (v >= 8'd128);
    mag = neg ? 256 - int'(v) : int'(v);
    h = mag / 100;
    t = (mag / 10) % 10;
    u = mag % 10;
    case (pos)
      3:       return neg ? 7'b0111111 : 7'b1111111;
      2:       return (h == 0) ? 7'b1111111 : code_of(h);
      1:       return (h == 0 && t == 0) ? 7'b1111111 : code_of(t);
      default: return code_of(u);
    endcase
  endfunction

  function automatic int an_pos(input logic [3:0] a);
    case (a)
      4'b1110: return 0;
      4'b1101: return 1;
      4'b1011: return 2;
      4'b0111: return 3;
      default: return -1;
    endcase
  endfunction

  task automatic start_conv(input logic [7:0] v, input logic sm);
    @(negedge clk);
    start = 1'b1;
    value = v;
    signed_mode = sm;
    @(posedge clk);
    #1 start = 1'b0;
  endtask

  // Capture the segment pattern shown for each digit over two full scan periods.
  task automatic read_display(output logic [27:0] disp, output int bad);
    int p;
    disp = 'x;
    bad = 0;
    for (int i = 0; i < 8 * CLK_DIV; i++) begin
      @(negedge clk);
      p = an_pos(an);
      if (p < 0) bad++;
      else disp[p*7 +: 7] = seg;
    end
  endtask

  task automatic compare_display(input string name);
    logic [27:0] disp;
    int bad;
    read_display(disp, bad);
    checks++;
    if (bad != 0) begin
      errors++;
      $display("FAIL %s an_onehot: %0d samples without exactly one low bit, required 0", name, bad);
    end
    for (int p = 0; p < 4; p++) begin
      checks++;
      if (disp[p*7 +: 7] !== exp_seg(p, cur_v, cur_sm)) begin
        errors++;
        $display("FAIL %s digit%0d: seg=%b required %b", name, p, disp[p*7 +: 7], exp_seg(p, cur_v, cur_sm));
      end
    end
  endtask

  // Checks busy/done over t+1..t+11 and that the old result stays displayed while busy.
  task automatic check_timing(input string name, input int ign_at);
    int p;
    for (int k = 1; k <= 11; k++) begin
      @(negedge clk);
      checks++;
      if (busy !== (k <= 9) || done !== (k == 10)) begin
        errors++;
        $display("FAIL %s timing t+%0d: busy=%b done=%b required busy=%b done=%b",
                 name, k, busy, done, (k <= 9), (k == 10));
      end
      if (k <= 9) begin
        p = an_pos(an);
        checks++;
        if (p < 0 || seg !== exp_seg(p, cur_v, cur_sm)) begin
          errors++;
          $display("FAIL %s hold t+%0d: an=%b seg=%b, old result required", name, k, an, seg);
        end
      end
      if (k == ign_at) begin
        start = 1'b1; value = 8'h01; signed_mode = 1'b0;
      end
      if (k == ign_at + 1) start = 1'b0;
    end
  endtask

  task automatic test_conversion(input string name, input logic [7:0] v, input logic sm);
    start_conv(v, sm);
    check_timing(name, -5);
    cur_v = v;
    cur_sm = sm;
    compare_display(name);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    start = 1'b1;
    value = 8'hFF;
    signed_mode = 1'b1;
    repeat (3) @(negedge clk);
    checks++;
    if (busy !== 1'b0 || done !== 1'b0 || an !== 4'b1110 || seg !== 7'b1000000) begin
      errors++;
      $display("FAIL reset: busy=%b done=%b an=%b seg=%b required 0 0 1110 1000000", busy, done, an, seg);
    end
    start = 1'b0;
    rst = 1'b0;
    cur_v = 8'h00;
    cur_sm = 1'b0;
  endtask

  task automatic test_scan();
    logic [3:0] exp_an;
    for (int i = 0; i <= 16; i++) begin
      if (i > 0) @(negedge clk);
      exp_an = ~(4'b0001 << ((i / CLK_DIV) % 4));
      checks++;
      if (an !== exp_an || busy !== 1'b0) begin
        errors++;
        $display("FAIL scan cycle%0d: an=%b busy=%b required an=%b busy=0", i, an, busy, exp_an);
      end
    end
  endtask

  task automatic test_ignored_start();
    start_conv(8'hC8, 1'b0);
    check_timing("ignored_start", 3);
    cur_v = 8'hC8;
    cur_sm = 1'b0;
    compare_display("ignored_start");
  endtask

  task automatic test_abort();
    int done_seen;
    start_conv(8'h55, 1'b0);
    for (int k = 1; k <= 4; k++) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    checks++;
    if (busy !== 1'b0 || done !== 1'b0 || an !== 4'b1110 || seg !== 7'b1000000) begin
      errors++;
      $display("FAIL abort: busy=%b done=%b an=%b seg=%b required 0 0 1110 1000000", busy, done, an, seg);
    end
    done_seen = 0;
    for (int k = 0; k < 15; k++) begin
      @(negedge clk);
      if (done !== 1'b0 || busy !== 1'b0) done_seen++;
    end
    checks++;
    if (done_seen != 0) begin
      errors++;
      $display("FAIL abort_quiet: %0d cycles with busy/done after abort, required 0", done_seen);
    end
    cur_v = 8'h00;
    cur_sm = 1'b0;
    compare_display("abort");
  endtask

  task automatic test_back_to_back();
    int k;
    start_conv(8'hF6, 1'b1);
    k = 0;
    while (done !== 1'b1 && k < 20) begin
      @(negedge clk);
      k++;
    end
    checks++;
    if (k != 10) begin
      errors++;
      $display("FAIL b2b_first_done: done after %0d cycles, required 10", k);
    end
    cur_v = 8'hF6;
    cur_sm = 1'b1;
    start = 1'b1;
    value = 8'h9C;
    signed_mode = 1'b0;
    @(posedge clk);
    #1 start = 1'b0;
    check_timing("back_to_back", -5);
    cur_v = 8'h9C;
    cur_sm = 1'b0;
    compare_display("back_to_back");
  endtask

  task automatic test_random();
    logic [7:0] v;
    logic sm;
    for (int i = 0; i < 12; i++) begin
      v = 8'($urandom_range(0, 255));
      sm = 1'($urandom_range(0, 1));
      test_conversion($sformatf("random%0d_%02h_%0d", i, v, sm), v, sm);
    end
  endtask

  initial begin
    start = 1'b0;
    value = 8'h00;
    signed_mode = 1'b0;
    rst = 1'b1;
    test_reset();
    test_scan();
    test_conversion("unsigned_ff", 8'hFF, 1'b0);
    test_conversion("signed_80", 8'h80, 1'b1);
    test_conversion("signed_f6", 8'hF6, 1'b1);
    test_conversion("unsigned_07", 8'h07, 1'b0);
    test_conversion("signed_7f", 8'h7F, 1'b1);
    test_conversion("zero", 8'h00, 1'b1);
    test_ignored_start();
    test_abort();
    test_back_to_back();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
